// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU mode codes, status-flag sources, flag bit positions
// and the processor status reset value.
package cpu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_ORA  = 5'd3;
  localparam logic [4:0] ALU_EOR  = 5'd4;
  localparam logic [4:0] ALU_ASL  = 5'd5;
  localparam logic [4:0] ALU_LSR  = 5'd6;
  localparam logic [4:0] ALU_ROL  = 5'd7;
  localparam logic [4:0] ALU_ROR  = 5'd8;
  localparam logic [4:0] ALU_PASS = 5'd9;

  typedef enum logic [2:0] {
    FS_ALU  = 3'd0,
    FS_BIT  = 3'd1,
    FS_LOAD = 3'd2,
    FS_SET  = 3'd3,
    FS_CLR  = 3'd4
  } flag_src_t;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_I = 2;
  localparam int unsigned FLAG_D = 3;
  localparam int unsigned FLAG_B = 4;
  localparam int unsigned FLAG_U = 5;
  localparam int unsigned FLAG_V = 6;
  localparam int unsigned FLAG_N = 7;

  localparam logic [7:0] RESET_P_DEFAULT = 8'h24;

endpackage

// File: rtl/status_reg.sv
// 6502 processor status register: masked flag updates from ALU/BIT/stack/set/clear,
// push image generation and the delayed interrupt mask seen by interrupt polling.
module status_reg #(
  parameter logic [7:0] RESET_P = cpu_pkg::RESET_P_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       upd_valid,
  input  logic [2:0] upd_sel,
  input  logic [7:0] upd_mask,
  input  logic [4:0] alu_mode,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  input  logic       alu_sign,
  input  logic [7:0] bit_operand,
  input  logic [7:0] data_in,
  input  logic       i_immediate,
  input  logic       sync,
  input  logic       push_brk,
  output logic [7:0] p_out,
  output logic [7:0] p_push,
  output logic       carry_flag,
  output logic       decimal_flag,
  output logic       irq_mask
);
  import cpu_pkg::*;

  logic [7:0] p_q, p_d;
  logic       irq_mask_q, irq_mask_d;
  logic       pending_q, pending_d;

  logic [7:0] cand;
  logic [7:0] wmask;
  logic       src_ok;
  logic       i_src;
  logic       i_write;
  logic       i_imm;

  always_comb begin
    cand   = p_q;
    src_ok = 1'b1;
    i_src  = 1'b0;
    case (upd_sel)
      FS_ALU: begin
        cand[FLAG_N] = alu_sign;
        cand[FLAG_V] = alu_overflow;
        cand[FLAG_Z] = alu_zero;
        // 6502 subtract stores not-borrow in C
        cand[FLAG_C] = (alu_mode == ALU_SUB) ? ~alu_carry : alu_carry;
      end
      FS_BIT: begin
        cand[FLAG_N] = bit_operand[7];
        cand[FLAG_V] = bit_operand[6];
        cand[FLAG_Z] = alu_zero;
      end
      FS_LOAD: begin
        cand  = data_in;
        i_src = 1'b1;
      end
      FS_SET: begin
        cand  = '1;
        i_src = 1'b1;
      end
      FS_CLR: begin
        cand  = '0;
        i_src = 1'b1;
      end
      default: src_ok = 1'b0;
    endcase

    wmask         = upd_mask;
    wmask[FLAG_U] = 1'b0;
    wmask[FLAG_B] = 1'b0;

    p_d = p_q;
    if (upd_valid && src_ok) begin
      p_d = (p_q & ~wmask) | (cand & wmask);
    end
    p_d[FLAG_U] = 1'b1;
    p_d[FLAG_B] = 1'b0;

    i_write = upd_valid && i_src && upd_mask[FLAG_I];
    i_imm   = i_write && (upd_sel == FS_LOAD) && i_immediate;

    // Sync samples the pre-update I; a same-cycle I write stays pending for the next sync.
    irq_mask_d = irq_mask_q;
    pending_d  = pending_q;
    if (sync && pending_q) begin
      irq_mask_d = p_q[FLAG_I];
      pending_d  = 1'b0;
    end
    if (i_imm) begin
      irq_mask_d = data_in[FLAG_I];
      pending_d  = 1'b0;
    end else if (i_write) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q        <= RESET_P;
      irq_mask_q <= 1'b1;
      pending_q  <= 1'b0;
    end else begin
      p_q        <= p_d;
      irq_mask_q <= irq_mask_d;
      pending_q  <= pending_d;
    end
  end

  assign p_out        = p_q;
  assign p_push       = {p_q[7:5], push_brk, p_q[3:0]};
  assign carry_flag   = p_q[FLAG_C];
  assign decimal_flag = p_q[FLAG_D];
  assign irq_mask     = irq_mask_q;

endmodule
